// File: rtl/fetch_queue.sv
// Decoupling instruction buffer between Fetch and Decode: a circular FIFO of
// {instr, pc} pairs with valid/ready handshakes, flush, occupancy count and drain flag.
module fetch_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic [ADDR_W:0]   count,
  input  logic              fetch_done,
  output logic              drained
);

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ZERO_COUNT = (ADDR_W+1)'(1'b0);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1'b1);
  localparam logic [ADDR_W-1:0] PTR_ZERO   = ADDR_W'(1'b0);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1'b1);

  logic [63:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              done_q, done_d;
  logic              drained_q, drained_d;
  logic              push_fire_s, pop_fire_s;

  // Full/empty come from the registered count only, so a full queue never
  // accepts a push on the strength of a same-cycle pop.
  assign in_ready    = (count_q != FULL_COUNT);
  assign out_valid   = (count_q != ZERO_COUNT);
  assign push_fire_s = in_valid && in_ready;
  assign pop_fire_s  = out_valid && out_ready;
  assign out_instr   = out_valid ? mem_q[head_q][63:32] : 32'd0;
  assign out_pc      = out_valid ? mem_q[head_q][31:0]  : 32'd0;
  assign count       = count_q;
  assign drained     = drained_q;

  // Next-state for pointers, occupancy and the drain flags; flush overrides all.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    done_d  = done_q | fetch_done;
    if (flush) begin
      head_d  = PTR_ZERO;
      tail_d  = PTR_ZERO;
      count_d = ZERO_COUNT;
      done_d  = 1'b0;
    end else begin
      if (push_fire_s) tail_d = tail_q + PTR_ONE;
      else             tail_d = tail_q;
      if (pop_fire_s)  head_d = head_q + PTR_ONE;
      else             head_d = head_q;
      case ({push_fire_s, pop_fire_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    drained_d = done_d && (count_d == ZERO_COUNT);
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= PTR_ZERO;
      tail_q    <= PTR_ZERO;
      count_q   <= ZERO_COUNT;
      done_q    <= 1'b0;
      drained_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      done_q    <= done_d;
      drained_q <= drained_d;
    end
  end

  // Entry storage needs no reset: it is only read while count marks it occupied.
  always_ff @(posedge clk) begin
    if (push_fire_s && !flush) begin
      mem_q[tail_q] <= {in_instr, in_pc};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        fetch_done = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic        in_ready, out_valid, drained;
  logic [31:0] out_instr, out_pc;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as {instr, pc}, latched done flag, drained view.
  logic [63:0] mq[$];
  bit          m_done = 1'b0;
  bit          m_drained = 1'b0;

  localparam logic [70:0] RESET_VEC = {1'b0, 1'b1, 1'b0, 4'd0, 64'd0};

  logic [70:0] act_s;
  assign act_s = {out_valid, in_ready, drained, count, out_instr, out_pc};

  fetch_queue #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .count(count), .fetch_done(fetch_done), .drained(drained)
  );

  always #5 clk = ~clk;

  function automatic logic [70:0] exp_vec();
    logic [63:0] h;
    h = (mq.size() != 0) ? mq[0] : 64'd0;
    return {mq.size() != 0, mq.size() != 8, m_drained, 4'(mq.size()), h};
  endfunction

  // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit rdy, input bit fl, input bit fd);
    bit push, pop;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl; fetch_done = fd;
    push = v && (mq.size() != 8);
    pop  = rdy && (mq.size() != 0);
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_done = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({ins, pc});
      if (fd) m_done = 1'b1;
    end
    m_drained = m_done && (mq.size() == 0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (act_s !== RESET_VEC) begin
        errors++;
        $display("FAIL reset_hold: got %h expected %h", act_s, RESET_VEC);
      end
    end
    reset = 1'b1;
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (act_s !== RESET_VEC || act_s !== exp_vec()) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", act_s, RESET_VEC);
    end
  endtask

  task automatic test_pass_through();
    step(1'b1, 32'h00500093, 32'h0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00500093 || out_pc !== 32'h0 || act_s !== exp_vec()) begin
      errors++;
      $display("FAIL pass_head: got %h expected %h", act_s, exp_vec());
    end
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || out_instr !== 32'd0) begin
      errors++;
      $display("FAIL pass_empty: got count=%0d valid=%b expected count=0 valid=0", count, out_valid);
    end
  endtask

  task automatic test_fill_stall();
    for (int i = 0; i < 8; i++) step(1'b1, $urandom, 32'(i * 4), 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd8 || in_ready !== 1'b0 || act_s !== exp_vec()) begin
      errors++;
      $display("FAIL fill_full: got %h expected %h", act_s, exp_vec());
    end
    step(1'b1, $urandom, 32'h20, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd8 || out_pc !== 32'h0 || act_s !== exp_vec()) begin
      errors++;
      $display("FAIL fill_ninth: got %h expected %h", act_s, exp_vec());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_pc !== 32'(i * 4) || act_s !== exp_vec()) begin
        errors++;
        $display("FAIL fill_order: got pc %h expected pc %h", out_pc, 32'(i * 4));
      end
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_drain: got count=%0d expected 0", count);
    end
  endtask

  task automatic test_full_simul();
    logic [31:0] held;
    held = $urandom;
    for (int i = 0; i < 8; i++) step(1'b1, $urandom, 32'(i * 4), 1'b0, 1'b0, 1'b0);
    step(1'b1, held, 32'h20, 1'b1, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd7 || out_pc !== 32'h4 || act_s !== exp_vec()) begin
      errors++;
      $display("FAIL full_simul: got count=%0d pc=%h expected count=7 pc=4", count, out_pc);
    end
    step(1'b1, held, 32'h20, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd8 || act_s !== exp_vec()) begin
      errors++;
      $display("FAIL full_retry: got count=%0d expected 8", count);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_pc !== 32'((i + 1) * 4) || act_s !== exp_vec()) begin
        errors++;
        $display("FAIL full_order: got pc %h expected pc %h", out_pc, 32'((i + 1) * 4));
      end
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL full_empty: got count=%0d expected 0", count);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] popped[$];
    int  i;
    bit  tog;
    bit  acc;
    i = 0;
    tog = 1'b1;
    for (int cyc = 0; cyc < 200 && (i < 20 || mq.size() != 0); cyc++) begin
      acc = (i < 20) && (mq.size() != 8);
      if (tog && mq.size() != 0) popped.push_back(out_pc);
      checks++;
      if (count > 4'd8 || act_s !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_cycle: got %h expected %h", act_s, exp_vec());
      end
      step(i < 20, $urandom, 32'(i * 4), tog, 1'b0, 1'b0);
      if (acc) i++;
      tog = ~tog;
    end
    checks++;
    if (popped.size() != 20) begin
      errors++;
      $display("FAIL wrap_total: got %0d entries expected 20", popped.size());
    end
    for (int k = 0; k < popped.size(); k++) begin
      checks++;
      if (popped[k] !== 32'(k * 4)) begin
        errors++;
        $display("FAIL wrap_order: got pc %h expected pc %h", popped[k], 32'(k * 4));
      end
    end
  endtask

  task automatic test_flush_drain();
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 32'(32'h40 + i * 4), 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL flush_pre: got count=%0d expected 5", count);
    end
    step(1'b1, $urandom, 32'h100, 1'b0, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || out_instr !== 32'd0 || act_s !== exp_vec()) begin
      errors++;
      $display("FAIL flush_clear: got %h expected %h", act_s, exp_vec());
    end
    step(1'b1, $urandom, 32'h200, 1'b0, 1'b0, 1'b0);
    step(1'b1, $urandom, 32'h204, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (drained !== 1'b0 || count !== 4'd1 || out_pc !== 32'h204) begin
      errors++;
      $display("FAIL drain_early: got drained=%b count=%0d expected drained=0 count=1", drained, count);
    end
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (drained !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL drain_set: got drained=%b expected 1", drained);
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (drained !== 1'b1) begin
        errors++;
        $display("FAIL drain_hold: got drained=%b expected 1", drained);
      end
    end
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (drained !== 1'b0 || act_s !== exp_vec()) begin
      errors++;
      $display("FAIL drain_flush: got drained=%b expected 0", drained);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      checks++;
      if (act_s !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle %0d: got %h expected %h", c, act_s, exp_vec());
      end
      step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 40) == 0, $urandom_range(0, 60) == 0);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    mq.delete();
    m_done = 1'b0;
    m_drained = 1'b0;
    checks++;
    if (act_s !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", act_s, RESET_VEC);
    end
    @(negedge clk);
    in_valid = 1'b0;
    fetch_done = 1'b0;
    reset = 1'b1;
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (act_s !== RESET_VEC || act_s !== exp_vec()) begin
      errors++;
      $display("FAIL reset_after: got %h expected %h", act_s, RESET_VEC);
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_fill_stall();
    test_full_simul();
    test_wrap();
    test_flush_drain();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_queue.md
Name:
fetch_queue

Overview:
- Decoupling instruction buffer between the Fetch stage and the Decode stage.
- Fetch pushes instruction/PC pairs; Decode pops them in program order. A stalled Decode therefore does not drop instructions and does not force Fetch to re-fetch them.
- Circular FIFO with valid/ready handshakes on both sides, a flush, an occupancy count, and a drain indication for end-of-program detection.

Parameters:
- DEPTH, 8, number of entries; must be a power of two, minimum 2.
- ADDR_W, 3, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets the block).
- flush  in  1  synchronous clear of all entries.
- in_valid  in  1  Fetch presents an instruction.
- in_ready  out  1  queue can accept an entry.
- in_instr  in  32  instruction word from Fetch.
- in_pc  in  32  PC of in_instr.
- out_valid  out  1  head entry is available to Decode.
- out_ready  in  1  Decode accepts the head entry.
- out_instr  out  32  head instruction word.
- out_pc  out  32  head PC.
- count  out  ADDR_W+1  current number of occupied entries.
- fetch_done  in  1  Fetch has issued its last instruction (level signal).
- drained  out  1  fetch_done is latched and the queue is empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - head, tail and count go to 0; the latched-done flag clears; storage is not required to clear.
  - Outputs during reset: out_valid=0, out_instr=0, out_pc=0, count=0, in_ready=1, drained=0.
- Push: push_fire = in_valid && in_ready.
  - Writes {in_instr, in_pc} at tail, then tail = tail+1 modulo DEPTH.
- Pop: pop_fire = out_valid && out_ready.
  - Advances head = head+1 modulo DEPTH.
- Handshake flags:
  - in_ready = (count != DEPTH), from registered count only. No combinational path from out_ready, so a full queue refuses a push even when a pop occurs in the same cycle.
  - out_valid = (count != 0).
- Head data: out_instr/out_pc are driven combinationally from the head entry and are forced to 0 when out_valid=0.
- Latency: an entry pushed in cycle N is visible on out_valid in cycle N+1. There is no same-cycle bypass, including when the queue is empty.
- Count update, same cycle: push only +1; pop only -1; both or neither, unchanged. In the both case head and tail each advance.
- Data held while stalled: Decode may hold out_ready=0 indefinitely. out_instr/out_pc must stay stable while out_valid=1 and no pop occurs.
- Ordering: strict FIFO; entries leave in push order.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no gap; full versus empty is resolved by count, not by pointer equality.
- Flush (synchronous, highest priority):
  - head, tail and count go to 0 on the next edge.
  - A push or pop in the same cycle is discarded.
  - The latched-done flag is also cleared.
- Drain:
  - The done flag sets on any cycle with fetch_done=1 and stays set until reset or flush.
  - drained = flag && (count==0), registered view; asserts the cycle after the last pop.
- Fetch behaviour: fetch_done asserted together with a final push is legal; that push is accepted.
- Protocol: in_instr/in_pc are ignored when in_valid=0. Pushing while in_ready=0 has no effect; Fetch must hold the entry.
- Reset mid-operation: all in-flight entries are lost; no partial state survives.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, then release -> out_valid=0, count=0, in_ready=1, drained=0, out_instr=0.
- Single pass-through: push instr 0x00500093 with pc 0x0 in cycle N, out_ready=1 -> out_valid=1 in cycle N+1 with out_instr=0x00500093 and out_pc=0x0; count returns to 0 after the pop.
- Fill and stall: push 8 entries with pcs 0x0..0x1C while out_ready=0 -> count=8, in_ready=0. A 9th in_valid with pc 0x20 is not accepted. Pop with out_ready=1 -> pcs emerge 0x0..0x1C in order.
- Full with simultaneous attempt: at count=8, assert in_valid and out_ready together -> pop of pc 0x0 only, count=7; the push is accepted on the following cycle.
- Wrap-around streaming: 20 back-to-back pushes (pc 0x0..0x4C) with out_ready toggling 1,0,1,0 -> all 20 pcs emerge in order, count never exceeds 8, no duplicates or drops.
- Flush and drain:
  - With 5 entries held, assert flush together with a push -> count=0 and out_valid=0 next cycle.
  - Then push 2 entries, assert fetch_done, pop both -> drained=1 the cycle after the second pop; drained stays 1 until flush or reset.
